// File: rtl/mccu_pkg.sv
// Shared types and instruction-field positions for the multicycle controller.
package mccu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_ADDI  = 3'b010,
        OP_ILL3  = 3'b011,
        OP_LOAD  = 3'b100,
        OP_STORE = 3'b101,
        OP_BEQZ  = 3'b110,
        OP_HALT  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_PASSB
    } alu_op_e;

    localparam int IR_W    = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 7;
    localparam int IMM_MSB = 8;
    localparam int IMM_W   = 9;

endpackage

// File: rtl/mccu_if.sv
// Memory and register-file bus of the multicycle controller; the controller is the master.
interface mccu_if #(
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [1:0]    rf_ra1;
    logic [1:0]    rf_ra2;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;
    logic [1:0]    rf_wa;
    logic [DW-1:0] rf_wd;
    logic          rf_we;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        output rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we,
        input  mem_rdata, mem_ack, rf_rd1, rf_rd2
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we,
        output mem_rdata, mem_ack, rf_rd1, rf_rd2
    );
endinterface

// File: rtl/mccu_alu.sv
// Modulo-2^DW ALU: add, subtract or pass operand B, with a zero flag on the result.
module mccu_alu
    import mccu_pkg::*;
#(
    parameter int DW = 16
) (
    input  alu_op_e       op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o,
    output logic          zero_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:   y_o = a_i + b_i;
            ALU_SUB:   y_o = a_i - b_i;
            ALU_PASSB: y_o = b_i;
            default:   y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for a 4-register, 16-bit-instruction ISA.
// Defining MCCU_BRANCH_EN turns op 110 into BEQZ; otherwise op 110 is illegal.
module multicycle_ctrl
    import mccu_pkg::*;
#(
    parameter int            DW       = 16,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    mccu_if.master        bus,
    output logic [DW-1:0] pc,
    output logic          instr_done,
    output logic          illegal,
    output logic          halted
);

    state_e          state_q, state_d;
    logic            run_q;
    logic [DW-1:0]   pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [DW-1:0]   alu_q, alu_d, ld_q, ld_d;

    op_e             op;
    logic            is_rr;
    logic [DW-1:0]   imm, pc_inc;
    alu_op_e         alu_op;
    logic [DW-1:0]   alu_b, alu_y;
    logic            alu_zero;

    assign op     = op_e'(ir_q[OP_MSB:OP_LSB]);
    assign is_rr  = (op == OP_ADD) || (op == OP_SUB);
    assign imm    = {{(DW-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:0]};
    assign pc_inc = pc_q + DW'(1);
    assign pc     = pc_q;

    // Operand B is the register value for ADD/SUB/BEQZ, the immediate for everything else.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm;
        if (is_rr) begin
            alu_b = b_q;
            if (op == OP_SUB) alu_op = ALU_SUB;
        end else if (op == OP_BEQZ) begin
            alu_b  = b_q;
            alu_op = ALU_PASSB;
        end
    end

    mccu_alu #(.DW(DW)) u_alu (
        .op_i  (alu_op),
        .a_i   (a_q),
        .b_i   (alu_b),
        .y_o   (alu_y),
        .zero_o(alu_zero)
    );

`ifndef MCCU_BRANCH_EN
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
`endif

    // run_q keeps the bus quiet until the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            ld_q    <= ld_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        a_d           = a_q;
        b_d           = b_q;
        alu_d         = alu_q;
        ld_d          = ld_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.rf_ra1    = '0;
        bus.rf_ra2    = '0;
        bus.rf_wa     = '0;
        bus.rf_wd     = '0;
        bus.rf_we     = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = pc_q;
                    if (bus.mem_ack) begin
                        ir_d    = bus.mem_rdata[IR_W-1:0];
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                bus.rf_ra1 = ir_q[RS1_MSB:RS1_LSB];
                bus.rf_ra2 = is_rr ? ir_q[RS2_MSB:RS2_LSB] : ir_q[RD_MSB:RD_LSB];
                a_d        = bus.rf_rd1;
                b_d        = bus.rf_rd2;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                alu_d = alu_y;
                case (op)
                    OP_ADD, OP_SUB, OP_ADDI: state_d = S_WB;
                    OP_LOAD, OP_STORE:       state_d = S_MEM;
                    OP_HALT:                 state_d = S_HALT;
`ifdef MCCU_BRANCH_EN
                    OP_BEQZ: begin
                        instr_done = 1'b1;
                        pc_d       = alu_zero ? (pc_inc + imm) : pc_inc;
                        state_d    = S_FETCH;
                    end
`endif
                    default: begin
                        illegal = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = alu_q;
                if (op == OP_STORE) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = b_q;
                end
                if (bus.mem_ack) begin
                    if (op == OP_STORE) begin
                        instr_done = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = S_FETCH;
                    end else begin
                        ld_d    = bus.mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                bus.rf_we  = 1'b1;
                bus.rf_wa  = ir_q[RD_MSB:RD_LSB];
                bus.rf_wd  = (op == OP_LOAD) ? ld_q : alu_q;
                instr_done = 1'b1;
                pc_d       = pc_inc;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a main DUT at RESET_PC=0 and a second at 0xFFFF for PC wrap.
module tb_multicycle_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pc, pc2;
    logic          done, ill, hlt, done2, ill2, hlt2;

    mccu_if #(.DW(DW)) bus ();
    mccu_if #(.DW(DW)) bus2 ();

    multicycle_ctrl #(.DW(DW), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .pc(pc), .instr_done(done), .illegal(ill), .halted(hlt)
    );

    multicycle_ctrl #(.DW(DW), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2),
        .pc(pc2), .instr_done(done2), .illegal(ill2), .halted(hlt2)
    );

    initial forever #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [15:0] regs [4];
    int          ack_lat = 1;
    int          n_we = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    assign bus.rf_rd1  = regs[bus.rf_ra1];
    assign bus.rf_rd2  = regs[bus.rf_ra2];
    assign bus2.rf_rd1 = (bus2.rf_ra1 == 2'd1) ? 16'hFFFF : 16'h0000;
    assign bus2.rf_rd2 = 16'h0000;

    // Memory responders and write monitor; ack comes after ack_lat request cycles.
    initial begin
        int cnt, cnt2;
        cnt = 0;
        cnt2 = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus2.mem_ack = 1'b0;
        bus2.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.rf_we) n_we++;
            if (reset || bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end
            if (!reset && bus.mem_req) begin
                cnt++;
                if (cnt > ack_lat) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr[7:0]];
                end
            end else cnt = 0;
            if (reset || bus2.mem_ack) begin
                bus2.mem_ack = 1'b0;
                cnt2 = 0;
            end
            if (!reset && bus2.mem_req) begin
                cnt2++;
                if (cnt2 > 1) begin
                    bus2.mem_ack = 1'b1;
                    bus2.mem_rdata = (bus2.mem_addr == 16'hFFFF) ? 16'h5201 : 16'hE000;
                end
            end else cnt2 = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load_prog(input logic [15:0] i0, input logic [15:0] i1,
                             input logic [15:0] i2, input logic [15:0] i3);
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
        mem[0] = i0;
        mem[1] = i1;
        mem[2] = i2;
        mem[3] = i3;
    endtask

    // Holds reset for two cycles, checks the reset state, releases after a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        step(2);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_pc", pc, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", hlt, 0);
        reset = 1'b0;
    endtask

    initial begin
        int we0, req_seen, pc_bad;
        regs[0] = 16'h0000;
        regs[1] = 16'h0003;
        regs[2] = 16'h0005;
        regs[3] = 16'h0000;

        // ADD R3,R1,R2 then SUB R0,R1,R2; second DUT runs ADDI R2,R1,1 at 0xFFFF
        ack_lat = 1;
        load_prog(16'h1B00, 16'h2300, 16'hE000, 16'hE000);
        do_reset();
        we0 = n_we;
        step();
        chk("add_fetch_req", bus.mem_req, 1);
        chk("add_fetch_addr", bus.mem_addr, 16'h0000);
        chk("wrap_fetch_addr", bus2.mem_addr, 16'hFFFF);
        step(2);
        chk("add_dec_ra1", bus.rf_ra1, 1);
        chk("add_dec_ra2", bus.rf_ra2, 2);
        step();
        chk("add_exec_done", done, 0);
        step();
        chk("add_wb_we", bus.rf_we, 1);
        chk("add_wb_wa", bus.rf_wa, 3);
        chk("add_wb_wd", bus.rf_wd, 16'h0008);
        chk("add_done_c5", done, 1);
        chk("addi_wb_we", bus2.rf_we, 1);
        chk("addi_wb_wa", bus2.rf_wa, 2);
        chk("addi_wb_wd", bus2.rf_wd, 16'h0000);
        chk("addi_done", done2, 1);
        chk("addi_illegal", ill2, 0);
        step();
        chk("add_pc", pc, 16'h0001);
        chk("add_next_addr", bus.mem_addr, 16'h0001);
        chk("wrap_pc", pc2, 16'h0000);
        chk("wrap_next_addr", bus2.mem_addr, 16'h0000);
        chk("wrap_next_req", bus2.mem_req, 1);
        step(4);
        chk("sub_wb_wa", bus.rf_wa, 0);
        chk("sub_wb_wd", bus.rf_wd, 16'hFFFE);
        chk("sub_done", done, 1);
        chk("wrap_halted", hlt2, 1);
        chk("add_sub_we_count", n_we - we0, 2);

        // LOAD R0,R1,-2 with two wait cycles on every access
        regs[1] = 16'h0010;
        ack_lat = 2;
        load_prog(16'h83FE, 16'hE000, 16'hE000, 16'hE000);
        mem[14] = 16'hBEEF;
        do_reset();
        step(5);
        chk("ld_exec_req", bus.mem_req, 0);
        step();
        chk("ld_mem_addr1", bus.mem_addr, 16'h000E);
        chk("ld_mem_we", bus.mem_we, 0);
        step();
        chk("ld_mem_addr2", bus.mem_addr, 16'h000E);
        step();
        chk("ld_mem_addr3", bus.mem_addr, 16'h000E);
        chk("ld_mem_req3", bus.mem_req, 1);
        chk("ld_done_early", done, 0);
        step();
        chk("ld_wb_we", bus.rf_we, 1);
        chk("ld_wb_wa", bus.rf_wa, 0);
        chk("ld_wb_wd", bus.rf_wd, 16'hBEEF);
        chk("ld_done", done, 1);

        // two illegal ops then op 110 at pc=2 (BEQZ R0,+4 when the branch feature is built in)
        regs[0] = 16'h0000;
        ack_lat = 1;
        load_prog(16'h6000, 16'h6000, 16'hC004, 16'hE000);
        do_reset();
        we0 = n_we;
        step(4);
        chk("ill_pulse", ill, 1);
        chk("ill_no_done", done, 0);
        chk("ill_no_we", bus.rf_we, 0);
        step();
        chk("ill_pc", pc, 16'h0001);
        chk("ill_next_addr", bus.mem_addr, 16'h0001);
        step(7);
`ifdef MCCU_BRANCH_EN
        chk("op110_illegal", ill, 0);
        chk("op110_done", done, 1);
        step();
        chk("op110_next_addr", bus.mem_addr, 16'h0007);
        chk("op110_pc", pc, 16'h0007);
`else
        chk("op110_illegal", ill, 1);
        chk("op110_done", done, 0);
        step();
        chk("op110_next_addr", bus.mem_addr, 16'h0003);
        chk("op110_pc", pc, 16'h0003);
`endif
        chk("ill_we_count", n_we - we0, 0);

        // STORE R2 -> M[R1+0]
        regs[1] = 16'h0020;
        regs[2] = 16'h1234;
        load_prog(16'hB200, 16'hE000, 16'hE000, 16'hE000);
        do_reset();
        we0 = n_we;
        step(5);
        chk("st_mem_req", bus.mem_req, 1);
        chk("st_mem_we", bus.mem_we, 1);
        chk("st_mem_addr", bus.mem_addr, 16'h0020);
        chk("st_mem_wdata", bus.mem_wdata, 16'h1234);
        chk("st_done_early", done, 0);
        step();
        chk("st_done_c6", done, 1);
        step();
        chk("st_pc", pc, 16'h0001);
        chk("st_next_addr", bus.mem_addr, 16'h0001);
        chk("st_next_we", bus.mem_we, 0);
        chk("st_we_count", n_we - we0, 0);

        // reset while the store is waiting for its ack
        ack_lat = 6;
        do_reset();
        step(11);
        chk("abort_pre_req", bus.mem_req, 1);
        chk("abort_pre_we", bus.mem_we, 1);
        reset = 1'b1;
        #1;
        chk("abort_req_drop", bus.mem_req, 0);
        chk("abort_we_drop", bus.mem_we, 0);
        chk("abort_pc", pc, 16'h0000);
        ack_lat = 1;
        do_reset();
        step();
        chk("abort_refetch_req", bus.mem_req, 1);
        chk("abort_refetch_addr", bus.mem_addr, 16'h0000);
        chk("abort_we_count", n_we - we0, 0);

        // HALT at pc=4, then 20 quiet cycles
        load_prog(16'h6000, 16'h6000, 16'h6000, 16'h6000);
        mem[4] = 16'hE000;
        do_reset();
        step(21);
        chk("halt_flag", hlt, 1);
        req_seen = 0;
        pc_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mem_req) req_seen++;
            if (pc !== 16'h0004) pc_bad++;
        end
        chk("halt_req_cycles", req_seen, 0);
        chk("halt_pc_changes", pc_bad, 0);
        chk("halt_pc", pc, 16'h0004);
        chk("halt_still", hlt, 1);
        chk("halt_no_we", bus.rf_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL take parameter DW, default 16: data/address width, legal range 16..32.
REQ-002 SHALL take parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have memory port: mem_req out 1; mem_we out 1; mem_addr out DW; mem_wdata out DW; mem_rdata in DW; mem_ack in 1.
REQ-005 SHALL have register-file port: rf_ra1 out 2; rf_ra2 out 2; rf_rd1 in DW; rf_rd2 in DW; rf_wa out 2; rf_wd out DW; rf_we out 1.
REQ-006 SHALL have status outputs: pc out DW; instr_done out 1 (retire pulse); illegal out 1 (pulse); halted out 1.

Function
REQ-007 SHALL decode a 16-bit instruction: op=[15:13], rd=[12:11], rs1=[10:9], rs2=[8:7], imm9=[8:0] sign-extended to DW.
REQ-008 SHALL implement ops: 000 ADD rd=rs1+rs2; 001 SUB rd=rs1-rs2; 010 ADDI rd=rs1+imm; 100 LOAD rd=M[rs1+imm]; 101 STORE M[rs1+imm]=R[ir[12:11]]; 111 HALT.
REQ-009 SHALL perform all arithmetic, address and PC computation modulo 2^DW; PC increments by 1 and wraps from 2^DW-1 to 0.
REQ-010 SHALL sequence states FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH} -> ... and HALT, one state per cycle except memory waits.
REQ-011 FETCH: mem_req=1, mem_we=0, mem_addr=pc held until mem_ack; IR latched from mem_rdata in the ack cycle; then DECODE.
REQ-012 DECODE: rf_ra1=ir[10:9], rf_ra2=ir[8:7] for ADD/SUB, else ir[12:11]; rf_rd1/rf_rd2 latched into A/B at end of cycle.
REQ-013 EXEC: ALU result latched; ADD/SUB/ADDI -> WB; LOAD/STORE -> MEM; HALT -> HALT; illegal op -> FETCH.
REQ-014 MEM: mem_req=1, mem_addr=ALU result, mem_we=1 and mem_wdata=B for STORE; all held stable until mem_ack.
REQ-015 STORE retires in its MEM ack cycle; LOAD latches mem_rdata in its ack cycle then goes to WB.
REQ-016 WB: rf_we=1 for exactly one cycle, rf_wa=rd, rf_wd = load data or ALU result; retires.
REQ-017 Retire cycle: instr_done=1 for one cycle, pc updates on the following edge, next state FETCH.
REQ-018 With mem_ack returned one cycle after mem_req, latencies SHALL be ADD/SUB/ADDI 5, LOAD 7, STORE 6 cycles.
REQ-019 mem_ack outside a request cycle SHALL be ignored; mem_req SHALL never deassert before ack.
REQ-020 Illegal op (011; 110 without branch feature): illegal=1 one cycle in EXEC, no register/memory write, pc+1, instr_done=0.
REQ-021 HALT: halted=1, mem_req=0, rf_we=0, pc frozen; exit only by reset.

Reset
REQ-022 Reset SHALL force state FETCH, pc=RESET_PC, IR/A/B/ALU=0, and all outputs 0 except pc, regardless of any in-flight request.
REQ-023 Reset deassertion SHALL begin a fetch at RESET_PC on the next clock edge; an ack belonging to an aborted request is the bench's responsibility.

Configuration
REQ-024 SHALL implement macro MCCU_BRANCH_EN: when defined, op 110 BEQZ: if R[ir[12:11]]==0 pc=pc+1+imm, else pc+1; retires in EXEC (4 cycles).
REQ-025 Without MCCU_BRANCH_EN, op 110 SHALL behave as illegal per REQ-020.

Structure
REQ-026 Package mccu_pkg SHALL hold the opcode enum, the state enum and field-position constants.
REQ-027 Sub-module mccu_alu SHALL provide add/sub/pass-B and zero flag, parametrised by DW.

Verification
REQ-028 Reset, R1=3, R2=5, ADD R3,R1,R2 -> rf_we once with rf_wa=3, rf_wd=8; instr_done at cycle 5; pc=1.
REQ-029 R1=0x0010, LOAD R0,R1,-2 (imm9=0x1FE), ack 3-cycle late -> mem_addr=0x000E held 3 cycles; rf_wd=mem_rdata.
REQ-030 R1=0xFFFF, ADDI R2,R1,1 -> rf_wd=0; pc=0xFFFF instruction then fetch at 0x0000.
REQ-031 MCCU_BRANCH_EN defined, R0=0, BEQZ R0,+4 at pc=2 -> next fetch at 7; undefined -> illegal pulse, next fetch at 3.
REQ-032 Reset asserted mid-STORE with mem_req=1 -> mem_req drops immediately, no rf_we, refetch at RESET_PC.
REQ-033 HALT at pc=4 -> halted=1, no mem_req for 20 cycles, pc stays 4.
